// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, memory target
// select and the byte/word geometry of the packing stream.
package program_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic TARGET_INSTRUCTION = 1'b0;
   localparam logic TARGET_DATA        = 1'b1;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned BYTE_WIDTH = 8;
   localparam int unsigned WORD_WIDTH = WORD_BYTES * BYTE_WIDTH;

   typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/program_loader_if.sv
// Load control, byte stream and memory write bus of the program loader.
// master = byte source / controller side, slave = the loader.
interface program_loader_if #(
   parameter int unsigned ADDR_WIDTH = 6
);
   logic                                         load_start;
   logic                                         load_target;
   logic [ADDR_WIDTH-1:0]                        load_base_address;
   logic [ADDR_WIDTH:0]                          load_count;
   logic                                         load_abort;
   logic                                         byte_valid;
   logic [program_loader_pkg::BYTE_WIDTH-1:0]    byte_data;
   logic                                         byte_ready;
   logic                                         instruction_write_enable;
   logic                                         data_write_enable;
   logic [ADDR_WIDTH-1:0]                        write_address;
   logic [program_loader_pkg::WORD_WIDTH-1:0]    write_data;
   logic                                         processor_hold;
   logic                                         busy;
   logic                                         done;

   modport master (
      output load_start, load_target, load_base_address, load_count, load_abort,
      output byte_valid, byte_data,
      input  byte_ready, instruction_write_enable, data_write_enable,
      input  write_address, write_data, processor_hold, busy, done
   );

   modport slave (
      input  load_start, load_target, load_base_address, load_count, load_abort,
      input  byte_valid, byte_data,
      output byte_ready, instruction_write_enable, data_write_enable,
      output write_address, write_data, processor_hold, busy, done
   );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs accepted bytes big-endian into a word; flags the beat that completes it.
module program_loader_byte_packer
   import program_loader_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  accept,
   input  logic [BYTE_WIDTH-1:0] byte_data,
   output word_t                 word_c,
   output logic                  word_complete_c
);
   localparam int unsigned HELD_WIDTH = WORD_WIDTH - BYTE_WIDTH;

   logic [1:0]            byte_count;
   logic [HELD_WIDTH-1:0] held;

   // Only the first three bytes need storage; the fourth is taken straight from the bus.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_count <= 2'd0;
         held       <= '0;
      end else if (clear) begin
         byte_count <= 2'd0;
         held       <= '0;
      end else if (accept) begin
         byte_count <= byte_count + 2'd1;
         held       <= word_c[HELD_WIDTH-1:0];
      end
   end

   assign word_c          = {held, byte_data};
   assign word_complete_c = accept && (byte_count == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Debug write port: streams bytes into 32-bit words and writes them sequentially
// into instruction or data memory while holding the processor in reset.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6
) (
   input logic             clock,
   input logic             reset,
   program_loader_if.slave bus
);
   localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

   state_t                state;
   state_t                next_state;
   logic                  target;
   logic [ADDR_WIDTH-1:0] addr_ptr;
   logic [ADDR_WIDTH:0]   words_left;
   logic                  busy_q;
   logic                  byte_accept_c;
   logic                  word_complete_c;
   word_t                 word_c;

   assign bus.byte_ready     = (state == ST_COLLECT);
   assign bus.busy           = busy_q;
   assign bus.processor_hold = busy_q;
   assign byte_accept_c      = bus.byte_valid && (state == ST_COLLECT);

   program_loader_byte_packer u_packer (
      .clock           (clock),
      .reset           (reset),
      .clear           (state == ST_IDLE),
      .accept          (byte_accept_c),
      .byte_data       (bus.byte_data),
      .word_c          (word_c),
      .word_complete_c (word_complete_c)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Abort takes priority over both word completion and load completion.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (bus.load_start)
               next_state = (bus.load_count == '0) ? ST_DONE : ST_COLLECT;
         end
         ST_COLLECT: begin
            if (bus.load_abort)      next_state = ST_IDLE;
            else if (word_complete_c) next_state = ST_WRITE;
         end
         ST_WRITE: begin
            if (bus.load_abort)                           next_state = ST_IDLE;
            else if (words_left == (ADDR_WIDTH+1)'(1))   next_state = ST_DONE;
            else                                          next_state = ST_COLLECT;
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Load parameters latched on start; address and remaining count step after each write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         target     <= TARGET_INSTRUCTION;
         addr_ptr   <= '0;
         words_left <= '0;
      end else if ((state == ST_IDLE) && bus.load_start) begin
         target     <= bus.load_target;
         addr_ptr   <= bus.load_base_address;
         words_left <= (bus.load_count > MAX_COUNT) ? MAX_COUNT : bus.load_count;
      end else if (state == ST_WRITE) begin
         addr_ptr   <= addr_ptr + ADDR_WIDTH'(1);
         words_left <= words_left - (ADDR_WIDTH+1)'(1);
      end
   end

   // Outputs registered from the next state so they line up with the state they describe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q                       <= 1'b0;
         bus.done                     <= 1'b0;
         bus.instruction_write_enable <= 1'b0;
         bus.data_write_enable        <= 1'b0;
         bus.write_address            <= '0;
         bus.write_data               <= '0;
      end else begin
         busy_q                       <= (next_state != ST_IDLE);
         bus.done                     <= (next_state == ST_DONE);
         bus.instruction_write_enable <= (next_state == ST_WRITE) && (target == TARGET_INSTRUCTION);
         bus.data_write_enable        <= (next_state == ST_WRITE) && (target == TARGET_DATA);
         if (next_state == ST_WRITE) begin
            bus.write_address <= addr_ptr;
            bus.write_data    <= word_c;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random loads checked against a word-level model.
module tb_program_loader;
   localparam int unsigned AW    = 6;
   localparam int          DEPTH = 64;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   program_loader_if #(.ADDR_WIDTH(AW)) bus ();
   program_loader #(.ADDR_WIDTH(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  stream [$];
   logic [38:0] obs_q  [$];
   int          done_cnt  = 0;
   int          exp_words = 0;
   bit          in_load   = 1'b0;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic vpat(input int cyc, input int mode);
      case (mode)
         0:       return 1'b1;
         1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   function automatic logic [63:0] all_outputs();
      return 64'({bus.byte_ready, bus.instruction_write_enable, bus.data_write_enable,
                  bus.write_address, bus.write_data, bus.processor_hold, bus.busy, bus.done});
   endfunction

   task automatic fill_random(input int n);
      stream.delete();
      for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_load(input logic tgt, input int base, input int cnt);
      bus.load_target       = tgt;
      bus.load_base_address = AW'(base);
      bus.load_count        = (AW+1)'(cnt);
      bus.load_start        = 1'b1;
      tick();
      bus.load_start = 1'b0;
   endtask

   // Write log: every strobe seen mid-cycle, plus handshake rules checked per cycle.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.instruction_write_enable || bus.data_write_enable) begin
            obs_q.push_back({bus.data_write_enable, bus.write_address, bus.write_data});
            check("single_enable", 64'(bus.instruction_write_enable & bus.data_write_enable), 64'd0);
            check("ready_in_write", 64'(bus.byte_ready), 64'd0);
            check("hold_in_write", 64'(bus.processor_hold), 64'd1);
         end else if (in_load && (obs_q.size() < exp_words)) begin
            check("ready_in_collect", 64'(bus.byte_ready), 64'd1);
         end
         if (bus.done) done_cnt++;
      end
   end

   task automatic run_load(input logic tgt, input int base, input int cnt, input int mode, input bit poke);
      int          nwords, nbytes, idx, cyc;
      logic        acc;
      logic [31:0] w;
      logic [5:0]  a;
      nwords = (cnt > DEPTH) ? DEPTH : cnt;
      nbytes = 4 * nwords;
      obs_q.delete();
      done_cnt  = 0;
      exp_words = nwords;
      start_load(tgt, base, cnt);
      in_load = 1'b1;
      check("hold_rise", 64'({bus.busy, bus.processor_hold}), 64'd3);
      if (poke) begin
         bus.load_target       = ~tgt;
         bus.load_base_address = AW'(base + 7);
         bus.load_count        = 7'd1;
      end
      idx = 0;
      cyc = 0;
      while (idx < nbytes && cyc < 4000) begin
         bus.byte_valid = vpat(cyc, mode);
         bus.byte_data  = stream[idx];
         bus.load_start = poke && (idx == 5);
         acc = bus.byte_valid && bus.byte_ready;
         tick();
         if (acc && ((idx % 4) == 3))
            check("write_latency", 64'({bus.instruction_write_enable, bus.data_write_enable}),
                  tgt ? 64'd1 : 64'd2);
         if (acc) idx++;
         cyc++;
      end
      bus.byte_valid = 1'b0;
      bus.load_start = 1'b0;
      check("bytes_consumed", 64'(idx), 64'(nbytes));
      for (int k = 0; k < 16 && done_cnt == 0; k++) tick();
      repeat (2) tick();
      in_load = 1'b0;
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("write_count", 64'(obs_q.size()), 64'(nwords));
      for (int i = 0; i < nwords && i < obs_q.size(); i++) begin
         w = {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
         a = 6'((base + i) % DEPTH);
         check("write_word", 64'(obs_q[i]), 64'({tgt, a, w}));
      end
      check("hold_fall", 64'({bus.busy, bus.processor_hold}), 64'd0);
   endtask

   initial begin
      bus.load_start        = 1'b0;
      bus.load_target       = 1'b0;
      bus.load_base_address = '0;
      bus.load_count        = '0;
      bus.load_abort        = 1'b0;
      bus.byte_valid        = 1'b0;
      bus.byte_data         = '0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_state", all_outputs(), 64'd0);
      reset = 1'b0;
      tick();

      stream = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
      run_load(1'b0, 0, 2, 0, 1'b0);

      stream = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      run_load(1'b1, 63, 2, 0, 1'b0);

      fill_random(20);
      run_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 5, 1, 1'b1);

      for (int r = 0; r < 3; r++) begin
         int n;
         n = int'($urandom_range(1, 8));
         fill_random(4 * n);
         run_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), n, 2, 1'b0);
      end

      stream.delete();
      run_load(1'b1, 5, 0, 0, 1'b0);

      fill_random(256);
      run_load(1'b0, int'($urandom_range(0, 63)), 100, 0, 1'b0);

      // Abort after two bytes of a word.
      fill_random(4);
      obs_q.delete();
      done_cnt = 0;
      start_load(1'b0, 10, 1);
      for (int i = 0; i < 2; i++) begin
         bus.byte_valid = 1'b1;
         bus.byte_data  = stream[i];
         tick();
      end
      bus.byte_valid = 1'b0;
      bus.load_abort = 1'b1;
      tick();
      bus.load_abort = 1'b0;
      check("abort_idle", 64'({bus.busy, bus.processor_hold, bus.byte_ready}), 64'd0);
      repeat (6) tick();
      check("abort_no_write", 64'(obs_q.size()), 64'd0);
      check("abort_no_done", 64'(done_cnt), 64'd0);

      // Abort in the same cycle the fourth byte transfers.
      start_load(1'b1, 20, 1);
      for (int i = 0; i < 3; i++) begin
         bus.byte_valid = 1'b1;
         bus.byte_data  = stream[i];
         tick();
      end
      bus.byte_data  = stream[3];
      bus.load_abort = 1'b1;
      tick();
      bus.load_abort = 1'b0;
      bus.byte_valid = 1'b0;
      check("abort_wins", 64'({bus.instruction_write_enable, bus.data_write_enable, bus.busy}), 64'd0);
      repeat (6) tick();
      check("abort4_no_write", 64'(obs_q.size()), 64'd0);
      check("abort4_no_done", 64'(done_cnt), 64'd0);

      // Asynchronous reset mid-word, mid-cycle.
      start_load(1'b0, 30, 2);
      for (int i = 0; i < 2; i++) begin
         bus.byte_valid = 1'b1;
         bus.byte_data  = stream[i];
         tick();
      end
      bus.byte_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", all_outputs(), 64'd0);
      tick();
      reset = 1'b0;
      tick();
      check("reset_no_write", 64'(obs_q.size()), 64'd0);

      fill_random(12);
      run_load(1'b1, int'($urandom_range(0, 63)), 3, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
